// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types and constants, also used by the PC register.
// No logic; constants and the pc/instr entry layout only.
package fetch_queue_pkg;

    localparam int FETCH_ADDR_WIDTH = 32;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_OFFSET     = 4;
    localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side request/response and decode-side valid/ready bundle of fetch_queue.
// master drives requests, memory data, flush and outReady; slave is the queue.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  pcValid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  flush;
    logic                  fetchStall;
    logic                  outValid;
    logic                  outReady;
    logic [ADDR_WIDTH-1:0] outPc;
    logic [ADDR_WIDTH-1:0] outIncPc;
    logic [DATA_WIDTH-1:0] outInstr;
    logic [CW-1:0]         count;

    modport master (
        output pc, pcValid, instr, flush, outReady,
        input  fetchStall, outValid, outPc, outIncPc, outInstr, count
    );

    modport slave (
        input  pc, pcValid, instr, flush, outReady,
        output fetchStall, outValid, outPc, outIncPc, outInstr, count
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Generic DEPTH x WIDTH FIFO with synchronous clear; read data is combinational from rdPtr.
// Write visible next cycle; pushes when full and pops when empty are dropped.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = push && (count != CW'(DEPTH));
    assign doPop  = pop && (count != '0);
    assign rdata  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            // storage is left as-is: count=0 hides every stale entry
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= wdata;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Pairs each memory response with its PC and queues the pairs for decode; flush kills all.
// Accept in N, write at end of N+1, outValid in N+2; stalls the PC register on count+pending >= DEPTH.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int OFFSET     = FETCH_OFFSET
) (
    input  logic           clk,
    input  logic           rstN,
    fetch_queue_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic                  reqPending;
    logic [ADDR_WIDTH-1:0] reqPc;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [OW-1:0]         occupancy;
    logic [CW-1:0]         count;
    entry_t                wrEntry;
    entry_t                rdEntry;

    // The in-flight request already owns a slot, so it counts toward occupancy;
    // a same-cycle pop is deliberately ignored to keep this path short.
    assign occupancy      = {1'b0, count} + OW'(reqPending);
    assign bus.fetchStall = (occupancy >= OW'(DEPTH));

    assign accept  = bus.pcValid && !bus.fetchStall && !bus.flush;
    assign push    = reqPending && !bus.flush;
    assign pop     = bus.outValid && bus.outReady;
    assign wrEntry = '{pc: reqPc, instr: bus.instr};

    always_ff @(posedge clk) begin
        if (!rstN) begin
            reqPending <= 1'b0;
            reqPc      <= '0;
        end else begin
            reqPending <= accept;
            if (accept) begin
                reqPc <= bus.pc;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .wdata (wrEntry),
        .rdata (rdEntry),
        .count (count)
    );

    assign bus.count    = count;
    assign bus.outValid = (count != '0);
    assign bus.outPc    = rdEntry.pc;
    assign bus.outInstr = rdEntry.instr;
    assign bus.outIncPc = rdEntry.pc + ADDR_WIDTH'(OFFSET);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: scoreboard filled by a posedge model, checked by a negedge monitor.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .OFFSET(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int maxCount = 0;
    bit monEn = 1'b0;

    fetch_entry_t expQ[$];
    fetch_entry_t seen[$];
    bit           mPend = 1'b0;
    logic [31:0]  mPendPc = '0;

    function automatic logic [31:0] instrOf(input logic [31:0] p);
        return 32'hA0 + ((p - RESET_VECTOR) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // reference model: what the queue must hold after each edge
    always @(posedge clk) begin
        bit stall;
        bit acc;
        if (!rstN || bus.flush) begin
            expQ.delete();
            mPend = 1'b0;
        end else begin
            stall = (expQ.size() + int'(mPend)) >= DEPTH;
            if (bus.outReady && expQ.size() != 0) void'(expQ.pop_front());
            if (mPend) expQ.push_back('{pc: mPendPc, instr: instrOf(mPendPc)});
            acc = bus.pcValid && !stall;
            mPend = acc;
            if (acc) mPendPc = bus.pc;
        end
    end

    // monitor: compare DUT state and head entry against the scoreboard
    always @(negedge clk) begin
        if (monEn) begin
            chk("count", 32'(bus.count), 32'(expQ.size()));
            chk("outValid", 32'(bus.outValid), 32'(expQ.size() != 0));
            chk("fetchStall", 32'(bus.fetchStall), 32'((expQ.size() + int'(mPend)) >= DEPTH));
            if (bus.outValid && expQ.size() != 0) begin
                chk("outPc", bus.outPc, expQ[0].pc);
                chk("outInstr", bus.outInstr, expQ[0].instr);
                chk("outIncPc", bus.outIncPc, expQ[0].pc + 32'd4);
                if (rstN && !bus.flush && bus.outReady)
                    seen.push_back('{pc: bus.outPc, instr: bus.outInstr});
            end
            if (int'(bus.count) > maxCount) maxCount = int'(bus.count);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] p, input logic rdy, input logic fl);
        bus.pcValid  = v;
        bus.pc       = p;
        bus.outReady = rdy;
        bus.flush    = fl;
        bus.instr    = mPend ? instrOf(mPendPc) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // leaves count=3 with one request in flight
    task automatic fill3(input logic [31:0] base);
        for (int i = 0; i < 4; i++) cyc(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        monEn = 1'b1;
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_outPc", bus.outPc, 32'h0);
        chk("rst_outInstr", bus.outInstr, 32'h0);
        chk("rst_outIncPc", bus.outIncPc, 32'h4);
        chk("rst_fetchStall", 32'(bus.fetchStall), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        rstN = 1'b1;

        // reset then stream
        seen.delete(); maxCount = 0;
        cyc(1'b1, 32'hBFC0_0000, 1'b1, 1'b0);
        chk("t1_valid_n1", 32'(bus.outValid), 32'd0);
        cyc(1'b1, 32'hBFC0_0004, 1'b1, 1'b0);
        chk("t1_valid_n2", 32'(bus.outValid), 32'd1);
        chk("t1_pc_n2", bus.outPc, 32'hBFC0_0000);
        chk("t1_instr_n2", bus.outInstr, 32'hA0);
        chk("t1_inc_n2", bus.outIncPc, 32'hBFC0_0004);
        cyc(1'b1, 32'hBFC0_0008, 1'b1, 1'b0);
        idle(4);
        chk("t1_nseen", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("t1_pc2", seen[2].pc, 32'hBFC0_0008);
            chk("t1_instr1", seen[1].instr, 32'hA1);
            chk("t1_instr2", seen[2].instr, 32'hA2);
        end
        chk("t1_maxcount", 32'(maxCount), 32'd1);

        // fill to full, then drain
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            if (i == 3) chk("t2_stall_at_sum4", 32'(bus.fetchStall), 32'd1);
        end
        chk("t2_count_full", 32'(bus.count), 32'd4);
        chk("t2_stall_full", 32'(bus.fetchStall), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_stall_drop", 32'(bus.fetchStall), 32'd0);
        chk("t2_count_drain", 32'(bus.count), 32'd3);
        idle(5);
        chk("t2_nseen", 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size(); i++)
            chk("t2_order", seen[i].pc, 32'h100 + 32'(4 * i));

        // steady push+pop at count=2 across pointer wrap
        seen.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        for (int i = 3; i < 15; i++) begin
            cyc(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            chk("t3_count2", 32'(bus.count), 32'd2);
        end
        idle(5);
        chk("t3_nseen", 32'(seen.size()), 32'd15);
        for (int i = 0; i < seen.size(); i++)
            chk("t3_order", seen[i].pc, 32'h200 + 32'(4 * i));

        // flush with three queued and one in flight
        seen.delete();
        fill3(32'h300);
        chk("t4_count_pre", 32'(bus.count), 32'd3);
        cyc(1'b1, 32'h2000, 1'b0, 1'b1);
        chk("t4_count_post", 32'(bus.count), 32'd0);
        chk("t4_valid_post", 32'(bus.outValid), 32'd0);
        cyc(1'b1, 32'h1000, 1'b1, 1'b0);
        idle(4);
        chk("t4_nseen", 32'(seen.size()), 32'd1);
        if (seen.size() != 0) chk("t4_first_pc", seen[0].pc, 32'h1000);

        // pops on empty queue are ignored
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t5_count", 32'(bus.count), 32'd0);
            chk("t5_valid", 32'(bus.outValid), 32'd0);
        end

        // reset mid-operation
        seen.delete();
        fill3(32'h500);
        rstN = 1'b0;
        cyc(1'b1, 32'h3000, 1'b1, 1'b0);
        rstN = 1'b1;
        chk("t6_outValid", 32'(bus.outValid), 32'd0);
        chk("t6_outPc", bus.outPc, 32'h0);
        chk("t6_outInstr", bus.outInstr, 32'h0);
        chk("t6_outIncPc", bus.outIncPc, 32'h4);
        chk("t6_fetchStall", 32'(bus.fetchStall), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        idle(4);
        cyc(1'b1, 32'h4000, 1'b1, 1'b0);
        cyc(1'b1, 32'h4004, 1'b1, 1'b0);
        idle(4);
        chk("t6_nseen", 32'(seen.size()), 32'd2);
        for (int i = 0; i < seen.size(); i++)
            chk("t6_order", seen[i].pc, 32'h4000 + 32'(4 * i));

        monEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
